// File: rtl/core_pkg.sv
// Shared branch-unit constants: funct3 encodings, 2-bit counter states and the
// saturating counter step used by the branch history table.
package core_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [1:0] BHT_RESET = WNT;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST) ? ST : ctr + 2'd1;
    else       return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_compare.sv
// Combinational RV conditional-branch comparator: raw compare flags plus the
// funct3-selected outcome and an illegal flag for the reserved encodings.
module branch_compare
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            eq,
  output logic            lt,
  output logic            ltu,
  output logic            outcome,
  output logic            illegal
);

  assign eq  = (rs1 == rs2);
  assign lt  = ($signed(rs1) < $signed(rs2));
  assign ltu = (rs1 < rs2);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; without them a latch is inferred.
    outcome = 1'b0;
    illegal = 1'b0;
    case (funct3)
      BEQ:     outcome = eq;
      BNE:     outcome = ~eq;
      BLT:     outcome = lt;
      BGE:     outcome = ~lt;
      BLTU:    outcome = ltu;
      BGEU:    outcome = ~ltu;
      default: illegal = 1'b1;  // 010/011: reserved, resolve as not-taken
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor with EX-stage resolution: IF looks up a 2-bit counter
// table, EX resolves the branch, retrains the table and reports redirects and stats.
module branch_predict_unit
  import core_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PC_W        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PC_W-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic [XLEN-1:0]  ex_rs2,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [PC_W-1:0]  ex_imm,
  input  logic             ex_pred_taken,
  output logic             res_valid,
  output logic             res_taken,
  output logic             res_mispredict,
  output logic [PC_W-1:0]  res_target,
  output logic             res_illegal,
  input  logic             stat_clear,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam int IDX = $clog2(BHT_ENTRIES);

  logic [1:0]     bht [BHT_ENTRIES];
  logic [IDX-1:0] if_idx;
  logic [IDX-1:0] ex_idx;

  logic cmp_eq, cmp_lt, cmp_ltu;
  logic outcome, illegal;
  logic fire, mispredict, train;
  logic [PC_W-1:0] next_pc;

  branch_compare #(.XLEN(XLEN)) u_compare (
    .funct3  (ex_funct3),
    .rs1     (ex_rs1),
    .rs2     (ex_rs2),
    .eq      (cmp_eq),
    .lt      (cmp_lt),
    .ltu     (cmp_ltu),
    .outcome (outcome),
    .illegal (illegal)
  );

  assign if_idx = if_pc[IDX+1:2];
  assign ex_idx = ex_pc[IDX+1:2];

  // Read is the pre-update value on an index collision; there is deliberately no bypass.
  assign if_pred_taken = bht[if_idx][1];

  assign fire       = ex_valid & ex_branch;
  assign train      = fire & ~illegal;
  assign mispredict = (outcome != ex_pred_taken) & ~illegal;
  assign next_pc    = outcome ? ex_pc + ex_imm : ex_pc + PC_W'(4);

  // NOTE: the table is reset entry by entry so predictions start weakly not-taken; it is a flop array, not a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= BHT_RESET;
    end else if (train) begin
      bht[ex_idx] <= ctr_next(bht[ex_idx], outcome);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid      <= 1'b0;
      res_taken      <= 1'b0;
      res_mispredict <= 1'b0;
      res_target     <= '0;
      res_illegal    <= 1'b0;
    end else if (fire) begin
      res_valid      <= 1'b1;
      res_taken      <= outcome;
      res_mispredict <= mispredict;
      res_target     <= next_pc;
      res_illegal    <= illegal;
    end else begin
      res_valid      <= 1'b0;
      res_mispredict <= 1'b0;
      res_illegal    <= 1'b0;
    end
  end

  // Saturating statistics; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (stat_clear) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (train && stat_branches != '1)
        stat_branches <= stat_branches + CNT_W'(1);
      if (fire && mispredict && stat_mispredicts != '1)
        stat_mispredicts <= stat_mispredicts + CNT_W'(1);
    end
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the combinational branch decision logic.
- Resolves RV32/RV64 conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) in EX from raw operands, with compare logic built in.
- Holds a direct-mapped bimodal history table (BHT) of 2-bit saturating counters. IF uses it for prediction; EX retrains it at resolution.
- Produces a registered resolution with a mispredict/redirect target for the hazard/fetch logic, plus saturating branch and mispredict statistics counters.

Parameters:
- XLEN, 32, operand width for compares (32 or 64).
- PC_W, 32, PC and immediate width.
- BHT_ENTRIES, 64, number of 2-bit counters; power of two, at least 2.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- if_pc  input  PC_W  fetch PC used for lookup.
- if_pred_taken  output  1  combinational prediction for if_pc (MSB of the indexed counter).
- ex_valid  input  1  EX stage holds a valid instruction this cycle.
- ex_branch  input  1  EX instruction is a conditional branch.
- ex_funct3  input  3  instruction[14:12].
- ex_rs1  input  XLEN  first source operand.
- ex_rs2  input  XLEN  second source operand.
- ex_pc  input  PC_W  PC of the EX instruction.
- ex_imm  input  PC_W  sign-extended B-type immediate.
- ex_pred_taken  input  1  prediction carried down the pipe with this instruction.
- res_valid  output  1  registered: a branch resolved in the previous cycle.
- res_taken  output  1  registered actual outcome.
- res_mispredict  output  1  registered: outcome differs from ex_pred_taken.
- res_target  output  PC_W  registered correct next PC.
- res_illegal  output  1  registered: ex_funct3 was 010 or 011 on a valid branch.
- stat_clear  input  1  synchronous clear of both statistics counters.
- stat_branches  output  CNT_W  resolved-branch count.
- stat_mispredicts  output  CNT_W  mispredict count.

Behaviour:
- BHT index is pc[IDX+1:2], where IDX = clog2(BHT_ENTRIES). The same mapping applies to if_pc and ex_pc.
- Reset (asynchronous, rst_n low):
  - every BHT entry goes to 2'b01 (weakly not-taken);
  - res_valid, res_taken, res_mispredict and res_illegal go to 0;
  - res_target goes to 0;
  - both statistics counters go to 0.
- Reset asserted mid-resolution clears outputs immediately. The pending update is discarded.
- Compare, combinational in EX:
  - eq = (rs1 == rs2);
  - lt = signed rs1 < signed rs2;
  - ltu = unsigned rs1 < rs2.
- Outcome by funct3: 000 eq, 001 !eq, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
- funct3 010/011: outcome is not-taken and illegal = 1.
- Resolve condition: fire = ex_valid & ex_branch.
- Registered outputs, one-cycle latency. At the clk edge after fire:
  - res_valid = 1;
  - res_taken = outcome;
  - res_mispredict = (outcome != ex_pred_taken) & ~illegal;
  - res_target = outcome ? ex_pc + ex_imm : ex_pc + 4 (modulo 2^PC_W, wrap silently);
  - res_illegal = illegal.
- When fire = 0, res_valid, res_mispredict and res_illegal return to 0 next cycle. res_taken and res_target hold their last values.
- BHT update is written on the same clk edge as the registered outputs, indexed by ex_pc:
  - taken: counter + 1, saturating at 11;
  - not-taken: counter - 1, saturating at 00.
- No BHT update when fire = 0 or illegal = 1.
- Read/write collision: if if_pc and ex_pc map to the same index in the same cycle, if_pred_taken shows the pre-update value. There is no bypass.
- Statistics update on the same edge as fire:
  - stat_branches += 1 on every non-illegal fire;
  - stat_mispredicts += 1 when the mispredict term is set.
  - Both saturate at all-ones and do not wrap.
  - stat_clear has priority over increment in the same cycle.
- ex_branch = 1 with ex_valid = 0 is a bubble: no update, no output.

Decomposition:
- Shared package (core_pkg) holds the funct3 constants BEQ/BNE/BLT/BGE/BLTU/BGEU, the 2-bit counter state constants (SNT=00, WNT=01, WT=10, ST=11), and the reset counter value WNT.
- One natural sub-module: branch_compare. It is purely combinational, parametrised on XLEN, and outputs eq/lt/ltu and outcome/illegal from funct3.
- The BHT stays inline as a register array with saturating update.

Test Plan:
- Reset release → if_pred_taken = 0 for if_pc 0x0, 0x4 and 0xFC. All res_* outputs = 0 and both stats = 0.
- BEQ, rs1 = rs2 = 0x5, ex_pc = 0x100, imm = 0x20, pred = 0:
  - next cycle res_valid = 1, res_taken = 1, res_mispredict = 1, res_target = 0x120, stat_mispredicts = 1;
  - afterwards if_pc = 0x100 gives if_pred_taken = 1.
- BLT rs1 = 0xFFFFFFFF, rs2 = 0x1 → taken. BLTU with the same operands → not-taken, res_target = ex_pc + 4.
- Four taken resolutions at pc 0x40 (counter saturates at 11), then one not-taken → if_pred_taken stays 1 (counter 10). A second not-taken → 0.
- funct3 = 010 with fire → res_illegal = 1, res_taken = 0, res_mispredict = 0; BHT and stats unchanged.
- Collision: lookup and taken update at pc 0x80 in the same cycle → old prediction 0 shown, 1 on the following cycle. Separately, with CNT_W = 2, four branches → stat_branches holds at 3. stat_clear together with fire → 0.
